// File: rtl/route_comp_lookahead_pipe.sv
// Two-stage lookahead route computation, NUM_CH independent valid/ready channels.
// Optional macro ROUTE_TORUS_EN selects torus wrap (default: mesh, edge hops flagged).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cur_x, cur_y            this router's coordinates (quasi-static)
//   in_valid/in_ready       per-channel request handshake
//   in_dst_x/in_dst_y       per-channel destination, channel c at [c*W +: W]
//   in_dir                  per-channel lookahead hop: 0 W,1 E,2 S,3 N,4 local
//   out_valid/out_ready     per-channel result handshake
//   out_prod                productive vector at neighbour (W,E,S,N,local = bit0..4)
//   out_err                 illegal direction or off-edge hop
//   busy_cnt                results delivered since reset, saturating at 255
module route_comp_lookahead_pipe #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH_COORD = 3,
    parameter int SIZE_X      = 8,
    parameter int SIZE_Y      = 8,
    parameter int NUM_PORT    = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WIDTH_COORD-1:0]        cur_x,
    input  logic [WIDTH_COORD-1:0]        cur_y,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [NUM_CH*WIDTH_COORD-1:0] in_dst_x,
    input  logic [NUM_CH*WIDTH_COORD-1:0] in_dst_y,
    input  logic [NUM_CH*3-1:0]           in_dir,
    output logic [NUM_CH-1:0]             out_valid,
    input  logic [NUM_CH-1:0]             out_ready,
    output logic [NUM_CH*NUM_PORT-1:0]    out_prod,
    output logic [NUM_CH-1:0]             out_err,
    output logic [7:0]                    busy_cnt
);
    localparam int W  = WIDTH_COORD;
    localparam int DW = WIDTH_COORD + 1;
    localparam logic [DW-1:0] LAST_X = DW'(SIZE_X - 1);
    localparam logic [DW-1:0] LAST_Y = DW'(SIZE_Y - 1);
`ifdef ROUTE_TORUS_EN
    localparam logic [DW-1:0] HALF_X = DW'(SIZE_X / 2);
    localparam logic [DW-1:0] HALF_Y = DW'(SIZE_Y / 2);
    localparam bit EVEN_X = (SIZE_X % 2) == 0;
    localparam bit EVEN_Y = (SIZE_Y % 2) == 0;
`endif

    logic [7:0]  busyCnt;
    logic [15:0] busySum;

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        logic [W-1:0]        dstX, dstY;
        logic [2:0]          dir;
        logic [DW-1:0]       curX, curY, nextX, nextY, dX, dY;
        logic                badDir, offEdge;
        logic                s1Valid, s1Err, s2Valid, s2Err;
        logic [DW-1:0]       s1Dx, s1Dy;
        logic [NUM_PORT-1:0] s2Prod, prod;
        logic                s1Load, s2Load;
        logic                doneX, doneY, goE, goN;
`ifdef ROUTE_TORUS_EN
        logic [DW-1:0]       absX, absY;
`endif

        assign dstX = in_dst_x[c*W +: W];
        assign dstY = in_dst_y[c*W +: W];
        assign dir  = in_dir[c*3 +: 3];
        assign curX = {1'b0, cur_x};
        assign curY = {1'b0, cur_y};

        // S1 can take a new flit when empty or when its flit moves on
        assign in_ready[c] = ~s1Valid | ~s2Valid | out_ready[c];
        assign s1Load      = in_valid[c] & in_ready[c];
        assign s2Load      = s1Valid & (~s2Valid | out_ready[c]);

        always_comb begin
            nextX   = curX;
            nextY   = curY;
            badDir  = 1'b0;
            offEdge = 1'b0;
            unique case (1'b1)
                dir == 3'd0: begin
`ifdef ROUTE_TORUS_EN
                    nextX = (curX == '0) ? LAST_X : curX - 1'b1;
`else
                    offEdge = (curX == '0);
                    nextX   = curX - 1'b1;
`endif
                end
                dir == 3'd1: begin
`ifdef ROUTE_TORUS_EN
                    nextX = (curX == LAST_X) ? '0 : curX + 1'b1;
`else
                    offEdge = (curX == LAST_X);
                    nextX   = curX + 1'b1;
`endif
                end
                dir == 3'd2: begin
`ifdef ROUTE_TORUS_EN
                    nextY = (curY == '0) ? LAST_Y : curY - 1'b1;
`else
                    offEdge = (curY == '0);
                    nextY   = curY - 1'b1;
`endif
                end
                dir == 3'd3: begin
`ifdef ROUTE_TORUS_EN
                    nextY = (curY == LAST_Y) ? '0 : curY + 1'b1;
`else
                    offEdge = (curY == LAST_Y);
                    nextY   = curY + 1'b1;
`endif
                end
                dir == 3'd4: begin
                end
                default: badDir = 1'b1;
            endcase
            // both operands < 2^W, so the difference fits DW-bit signed
            dX = {1'b0, dstX} - nextX;
            dY = {1'b0, dstY} - nextY;
        end

        always_comb begin
            doneX = (s1Dx == '0);
            doneY = (s1Dy == '0);
`ifdef ROUTE_TORUS_EN
            // flip the sign when the wrap path is shorter; exact half -> E/N
            absX = s1Dx[DW-1] ? -s1Dx : s1Dx;
            absY = s1Dy[DW-1] ? -s1Dy : s1Dy;
            goE  = (EVEN_X && absX == HALF_X) ||
                   (~s1Dx[DW-1] ^ (absX > HALF_X));
            goN  = (EVEN_Y && absY == HALF_Y) ||
                   (~s1Dy[DW-1] ^ (absY > HALF_Y));
`else
            goE = ~s1Dx[DW-1];
            goN = ~s1Dy[DW-1];
`endif
            prod = '0;
            if (!s1Err) begin
                prod[0] = ~doneX & ~goE;
                prod[1] = ~doneX & goE;
                prod[2] = ~doneY & ~goN;
                prod[3] = ~doneY & goN;
                prod[4] = doneX & doneY;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1Valid <= 1'b0;
                s1Err   <= 1'b0;
                s1Dx    <= '0;
                s1Dy    <= '0;
                s2Valid <= 1'b0;
                s2Err   <= 1'b0;
                s2Prod  <= '0;
            end else begin
                if (s1Load) begin
                    s1Valid <= 1'b1;
                    s1Err   <= badDir | offEdge;
                    s1Dx    <= dX;
                    s1Dy    <= dY;
                end else if (s2Load) begin
                    s1Valid <= 1'b0;
                end
                if (s2Load) begin
                    s2Valid <= 1'b1;
                    s2Prod  <= prod;
                    s2Err   <= s1Err;
                end else if (out_ready[c]) begin
                    s2Valid <= 1'b0;
                end
            end
        end

        assign out_valid[c]                   = s2Valid;
        assign out_err[c]                     = s2Err;
        assign out_prod[c*NUM_PORT +: NUM_PORT] = s2Prod;
    end

    always_comb begin
        busySum = {8'd0, busyCnt};
        for (int i = 0; i < NUM_CH; i++) begin
            busySum = busySum + {15'd0, out_valid[i] & out_ready[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busyCnt <= 8'd0;
        end else begin
            busyCnt <= (busySum > 16'd255) ? 8'd255 : busySum[7:0];
        end
    end

    assign busy_cnt = busyCnt;

endmodule

// File: tb/tb_route_comp_lookahead_pipe.sv
// Bench for route_comp_lookahead_pipe: directed cases plus random traffic
// checked against a per-channel queue model of the routing rules.
module tb_route_comp_lookahead_pipe;
    localparam int NCH = 4;
    localparam int WC  = 3;
    localparam int SX  = 8;
    localparam int SY  = 8;
`ifdef ROUTE_TORUS_EN
    localparam bit TORUS = 1'b1;
`else
    localparam bit TORUS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [WC-1:0]     cur_x, cur_y;
    logic [NCH-1:0]    in_valid, in_ready;
    logic [NCH*WC-1:0] in_dst_x, in_dst_y;
    logic [NCH*3-1:0]  in_dir;
    logic [NCH-1:0]    out_valid, out_ready, out_err;
    logic [NCH*5-1:0]  out_prod;
    logic [7:0]        busy_cnt;

    int checks = 0;
    int errors = 0;
    int expBusy = 0;
    logic [NCH-1:0] lastAcc;
    logic [5:0] sbq [NCH][$];

    always #5 clk = ~clk;

    route_comp_lookahead_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .cur_x(cur_x), .cur_y(cur_y),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dst_x(in_dst_x), .in_dst_y(in_dst_y), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_err(out_err), .busy_cnt(busy_cnt)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {err, prod}: walk one hop, then take the shortest way to the destination
    function automatic logic [5:0] model(int cx, int cy, int dx, int dy, int dir);
        int nx = cx;
        int ny = cy;
        int ddx, ddy;
        bit bad = 1'b0;
        case (dir)
            0: begin bad = !TORUS && cx == 0;      nx = (cx + SX - 1) % SX; end
            1: begin bad = !TORUS && cx == SX - 1; nx = (cx + 1) % SX;      end
            2: begin bad = !TORUS && cy == 0;      ny = (cy + SY - 1) % SY; end
            3: begin bad = !TORUS && cy == SY - 1; ny = (cy + 1) % SY;      end
            4: ;
            default: bad = 1'b1;
        endcase
        if (bad) return 6'b100000;
        ddx = dx - nx;
        ddy = dy - ny;
        if (TORUS) begin
            if (2 * ddx > SX) ddx -= SX;
            else if (2 * ddx < -SX) ddx += SX;
            else if (2 * ddx == -SX) ddx = -ddx;
            if (2 * ddy > SY) ddy -= SY;
            else if (2 * ddy < -SY) ddy += SY;
            else if (2 * ddy == -SY) ddy = -ddy;
        end
        return {1'b0, ddx == 0 && ddy == 0, ddy > 0, ddy < 0, ddx > 0, ddx < 0};
    endfunction

    task automatic setReq(int c, int dx, int dy, int dir);
        in_dst_x[c*WC +: WC] = WC'(dx);
        in_dst_y[c*WC +: WC] = WC'(dy);
        in_dir[c*3 +: 3]     = 3'(dir);
    endtask

    task automatic randReq(int c);
        setReq(c, $urandom_range(0, SX - 1), $urandom_range(0, SY - 1),
               $urandom_range(0, 7));
    endtask

    // one clock: score the handshakes that the coming edge will perform
    task automatic cycle();
        int nDel = 0;
        logic [5:0] e;
        @(negedge clk);
        chk("busy_track", 32'(busy_cnt), 32'(expBusy));
        lastAcc = in_valid & in_ready;
        for (int c = 0; c < NCH; c++) begin
            if (out_valid[c] && out_ready[c]) begin
                if (sbq[c].size() == 0) begin
                    chk($sformatf("extra_out_ch%0d", c), 32'(out_valid[c]), 0);
                end else begin
                    e = sbq[c].pop_front();
                    chk($sformatf("prod_ch%0d", c), 32'(out_prod[c*5 +: 5]), 32'(e[4:0]));
                    chk($sformatf("err_ch%0d", c), 32'(out_err[c]), 32'(e[5]));
                    nDel++;
                end
            end
            if (lastAcc[c]) begin
                sbq[c].push_back(model(int'(cur_x), int'(cur_y),
                    int'(in_dst_x[c*WC +: WC]), int'(in_dst_y[c*WC +: WC]),
                    int'(in_dir[c*3 +: 3])));
            end
        end
        expBusy = (expBusy + nDel > 255) ? 255 : expBusy + nDel;
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int c = 0; c < NCH; c++) sbq[c].delete();
        expBusy = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        clearModel();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(string tag, int c, int cx, int cy, int dx, int dy,
                            int dir, logic [4:0] eProd, logic eErr);
        cur_x = WC'(cx);
        cur_y = WC'(cy);
        out_ready = '1;
        setReq(c, dx, dy, dir);
        in_valid = NCH'(1) << c;
        cycle();
        in_valid = '0;
        chk({tag, "_lat1"}, 32'(out_valid[c]), 0);
        cycle();
        chk({tag, "_valid"}, 32'(out_valid[c]), 1);
        chk({tag, "_prod"}, 32'(out_prod[c*5 +: 5]), 32'(eProd));
        chk({tag, "_err"}, 32'(out_err[c]), 32'(eErr));
        cycle();
    endtask

    initial begin
        int idx;
        int bound;
        logic [4:0] held;
        int bpX [4] = '{1, 6, 2, 5};
        int bpY [4] = '{7, 0, 5, 3};
        int bpD [4] = '{1, 3, 4, 6};

        reset_n   = 1'b0;
        cur_x     = '0;
        cur_y     = '0;
        in_valid  = '0;
        out_ready = '0;
        in_dst_x  = '0;
        in_dst_y  = '0;
        in_dir    = '0;
        lastAcc   = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_prod", 32'(out_prod), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_busy", 32'(busy_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'({NCH{1'b1}}));

        directed("east", 0, 3, 3, 5, 3, 1, 5'b00010, 1'b0);
        directed("north_local", 0, 3, 3, 3, 4, 3, 5'b10000, 1'b0);
        directed("bad_dir", 2, 3, 3, 3, 4, 7, 5'b00000, 1'b1);
        if (TORUS) directed("west_wrap", 0, 0, 2, 6, 2, 0, 5'b00001, 1'b0);
        else directed("west_edge", 0, 0, 2, 6, 2, 0, 5'b00000, 1'b1);

        // back-pressure on channel 1
        doReset();
        cur_x = 3'd2;
        cur_y = 3'd5;
        out_ready = 4'b1101;
        idx = 0;
        held = '0;
        setReq(1, bpX[0], bpY[0], bpD[0]);
        in_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (lastAcc[1]) idx++;
            if (idx < 4) setReq(1, bpX[idx], bpY[idx], bpD[idx]);
            else in_valid = '0;
            if (k == 1) begin
                chk("bp_accepts", 32'(idx), 2);
                chk("bp_ready_drop", 32'(in_ready[1]), 0);
                held = out_prod[5 +: 5];
            end else if (k > 1) begin
                chk("bp_hold", 32'(out_prod[5 +: 5]), 32'(held));
            end
        end
        out_ready = '1;
        bound = 0;
        while ((idx < 4 || sbq[1].size() != 0) && bound < 40) begin
            cycle();
            if (lastAcc[1]) idx++;
            if (idx < 4) setReq(1, bpX[idx], bpY[idx], bpD[idx]);
            else in_valid = '0;
            bound++;
        end
        chk("bp_drained", 32'(sbq[1].size()), 0);
        chk("bp_busy", 32'(busy_cnt), 4);

        // full-rate traffic on every channel
        in_valid = '1;
        out_ready = '1;
        for (int k = 0; k < 300; k++) begin
            if (k % 64 == 0) begin
                cur_x = WC'($urandom_range(0, SX - 1));
                cur_y = WC'($urandom_range(0, SY - 1));
            end
            for (int c = 0; c < NCH; c++) randReq(c);
            cycle();
            chk("tput_accept", 32'(lastAcc), 32'({NCH{1'b1}}));
            if (k >= 2) chk("tput_valid", 32'(out_valid), 32'({NCH{1'b1}}));
        end

        // random valid and ready
        for (int k = 0; k < 200; k++) begin
            if (k % 50 == 0) begin
                cur_x = WC'($urandom_range(0, SX - 1));
                cur_y = WC'($urandom_range(0, SY - 1));
            end
            in_valid  = NCH'($urandom);
            out_ready = NCH'($urandom);
            for (int c = 0; c < NCH; c++) randReq(c);
            cycle();
        end
        in_valid = '0;
        out_ready = '1;
        repeat (4) cycle();
        for (int c = 0; c < NCH; c++)
            chk($sformatf("rnd_drained_ch%0d", c), 32'(sbq[c].size()), 0);
        chk("busy_sat", 32'(busy_cnt), 255);

        // asynchronous reset with both stages full
        in_valid = '1;
        out_ready = '0;
        for (int c = 0; c < NCH; c++) randReq(c);
        cycle();
        cycle();
        chk("mid_full", 32'(out_valid), 32'({NCH{1'b1}}));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_prod", 32'(out_prod), 0);
        chk("async_err", 32'(out_err), 0);
        chk("async_busy", 32'(busy_cnt), 0);
        clearModel();
        in_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = '1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("post_rst_idle", 32'(out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/route_comp_lookahead_pipe.md
Name: route_comp_lookahead_pipe

Overview:
- Parametrised, pipelined lookahead route-computation unit for the BLESS router.
- Replaces one-port combinational route computation with NUM_CH independent channels. Each channel computes the productive-port vector a flit will need at the neighbour router it is about to enter.
- Runtime-selectable lookahead direction per flit.
- Two-stage registered pipeline with valid/ready handshake per channel. Sits between the input latches and the port-allocation stage.

Parameters:
- NUM_CH, 4, number of independent route channels.
- WIDTH_COORD, 3, bits per X/Y coordinate.
- SIZE_X, 8, network columns (1..2^WIDTH_COORD).
- SIZE_Y, 8, network rows (1..2^WIDTH_COORD).
- NUM_PORT, 5, productive vector width; fixed encoding: bit0 W, bit1 E, bit2 S, bit3 N, bit4 local.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cur_x  in  WIDTH_COORD  this router's X; quasi-static.
- cur_y  in  WIDTH_COORD  this router's Y; quasi-static.
- in_valid  in  NUM_CH  per-channel request valid.
- in_ready  out  NUM_CH  per-channel accept.
- in_dst_x  in  NUM_CH*WIDTH_COORD  destination X, channel c at [c*W +: W].
- in_dst_y  in  NUM_CH*WIDTH_COORD  destination Y.
- in_dir  in  NUM_CH*3  lookahead direction: 0 W, 1 E, 2 S, 3 N, 4 local (no hop); 5-7 illegal.
- out_valid  out  NUM_CH  result valid.
- out_ready  in  NUM_CH  downstream accept.
- out_prod  out  NUM_CH*NUM_PORT  productive vector.
- out_err  out  NUM_CH  illegal direction or off-edge hop.
- busy_cnt  out  8  number of results delivered since reset, saturating at 255.

Behaviour:
- Reset: all pipeline valid bits 0, out_valid=0, out_prod=0, out_err=0, busy_cnt=0. in_ready=1 once reset_n is high.
- Stage 1 (S1), on in_valid&in_ready:
  - Register next coordinate: W: x-1; E: x+1; S: y-1; N: y+1; local: unchanged.
  - Register destination.
  - Register signed deltas (WIDTH_COORD+1 bits): dX=dst_x-next_x, dY=dst_y-next_y.
- Stage 2 (S2), from the S1 registers:
  - doneX = (dX==0); doneY = (dY==0).
  - E = ~doneX & dX>0; W = ~doneX & dX<0.
  - N = ~doneY & dY>0; S = ~doneY & dY<0.
  - local = doneX & doneY.
  - Exactly one of E/W is set when ~doneX; likewise N/S when ~doneY.
- Latency: 2 cycles from accepted input to out_valid when unstalled. Throughput: 1 per channel per cycle.
- Handshake, per channel independent:
  - in_ready = ~s1_valid | (~out_valid | out_ready).
  - S2 holds out_prod/out_err stable while out_valid & ~out_ready.
  - S1 holds data until it is moved into S2.
  - No combinational path from in_valid to out_valid.
- Simultaneous accept into S1 and drain from S2 in the same cycle is legal: no bubble, no loss.
- Errors:
  - in_dir 5-7: out_err=1, out_prod=0.
  - Edge violation (mesh mode): out_err=1, out_prod=0.
  - An error result still consumes a slot and completes its handshake.
- busy_cnt: increments on each out_valid&out_ready over all channels. Counts up to NUM_CH per cycle, saturates at 255.
- Asynchronous reset mid-stream: all in-flight results discarded. Outputs return to reset values immediately.
- dst coordinates >= SIZE are illegal input; the result is don't-care, with no lockup.

Optional Feature:
- Macro: ROUTE_TORUS_EN.
- Defined (torus):
  - Next coordinate wraps modulo SIZE_X/SIZE_Y.
  - Direction chosen by the shortest wrap path: if |d| > SIZE/2, reverse the sign.
  - Tie at exactly SIZE/2 resolves to E / N.
  - No edge errors.
- Undefined (mesh):
  - W at x=0, E at x=SIZE_X-1, S at y=0, N at y=SIZE_Y-1 set out_err=1, out_prod=0.
  - Deltas are plain signed differences.

Test Plan:
- Mesh, cur=(3,3), ch0 dst=(5,3) dir=E -> next=(4,3), 2 cycles later out_prod=5'b00010, err=0.
- Mesh, cur=(3,3), dst=(3,4) dir=N -> next=(3,4), out_prod=5'b10000 (local); dir=7 -> out_err=1, out_prod=0.
- Mesh, cur=(0,2), dir=W -> out_err=1; same case with ROUTE_TORUS_EN, SIZE_X=8, dst=(6,2):
  - next=(7,2), dX=-1 -> out_prod=5'b00001.
- Back-pressure: stream 4 requests on ch1, hold out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - Results emerge in order, unchanged, with no loss.
  - busy_cnt=4 at the end.
- All 4 channels valid every cycle for 300 cycles, out_ready=1 -> each channel delivers 1 result per cycle; busy_cnt saturates at 255.
- Assert reset_n low while S1 and S2 are full -> out_valid=0 asynchronously, busy_cnt=0, no stale output after release.
